tap_delay_line: RTL and testbench
=================================

# tap_delay_line

Parametrised multi-tap delay line for the sample path. It stores the last DEPTH samples in a circular buffer and presents NTAPS taps, each with its own delay that can be changed at run time. Each tap has a valid flag that shows whether the tap has been filled yet. It replaces the fixed 8-bit × 256 tapped shift register, whose taps were hard-wired at 5, 10, 15 and 20. It sits between the sample source and the correlator/filter stages.

## Interface
- WIDTH, 8: sample width in bits.
- DEPTH, 256: buffer depth in samples. Must be a power of 2 and ≥ 2. This is also the maximum delay.
- NTAPS, 4: number of taps, 1..16.
- DEFAULT_STEP, 5: reset delay of tap k is min((k+1)·DEFAULT_STEP, DEPTH).
- DW = $clog2(DEPTH)+1 (derived): delay field width.

Ports:
- clk  in  1: clock. All logic is rising-edge.
- rst  in  1: asynchronous, active-high reset.
- clear  in  1: synchronous flush. Resets the pointer and fill level; memory contents are not cleared.
- shift  in  1: accept data_in this cycle.
- data_in  in  WIDTH: input sample.
- cfg_we  in  1: write a tap delay.
- cfg_sel  in  $clog2(NTAPS) (min 1): index of the tap being written.
- cfg_delay  in  DW: requested delay in samples.
- tap_data  out  NTAPS·WIDTH: tap k occupies bits [k·WIDTH +: WIDTH].
- tap_valid  out  NTAPS: tap k holds a real sample.
- out_strobe  out  1: one-cycle pulse; taps were updated on this edge.
- fill_level  out  DW: samples accepted since reset/clear, saturating at DEPTH.

## Operation
- Storage: mem[DEPTH] of WIDTH bits, plus wr_ptr ($clog2(DEPTH) bits, wraps modulo DEPTH).
- Delay semantics: delay d means tap output equals the sample accepted d shifts ago, counting the current shift as 1.
  - d=1 gives the sample accepted on this edge.
  - This is equivalent to sr[d-1] of an ideal shift register.
- Shift cycle (shift=1, clear=0), all updates on the same edge:
  - mem[wr_ptr] ← data_in.
  - wr_ptr ← wr_ptr+1.
  - fill_level ← min(fill_level+1, DEPTH).
  - For each k: tap_data[k] ← (d_k==1) ? data_in : mem[(wr_ptr − (d_k−1)) mod DEPTH], read before the write.
  - For each k: tap_valid[k] ← (fill_level+1 ≥ d_k).
  - out_strobe ← 1.
- Non-shift cycle: tap_data, tap_valid, wr_ptr and fill_level hold; out_strobe ← 0.
- Config write (cfg_we=1):
  - d[cfg_sel] ← clamp(cfg_delay): 0 becomes 1, values > DEPTH become DEPTH.
  - cfg_sel ≥ NTAPS: the write is ignored.
  - tap_data and tap_valid are not recomputed until the next shift.
- Same cycle cfg_we + shift: the shift uses the old delay. The new delay applies from the next shift.
- clear=1 (takes priority over shift):
  - wr_ptr ← 0, fill_level ← 0, tap_valid ← 0, out_strobe ← 0.
  - data_in is not stored.
  - tap_data holds.
  - Tap delays are kept.
- Wrap-around: after DEPTH shifts, mem[wr_ptr] is overwritten. A tap with d=DEPTH reads that location before it is overwritten, so it returns the sample exactly DEPTH shifts old.

## Timing
- Reset values (rst=1, asynchronous):
  - tap_data=0, tap_valid=0, out_strobe=0, fill_level=0, wr_ptr=0.
  - d_k = min((k+1)·DEFAULT_STEP, DEPTH).
- Latency: tap outputs are registered. They are visible the cycle after the shift edge, coincident with out_strobe=1.
- Throughput: one sample per clock. shift may be held high continuously.
- Reset mid-stream: everything returns to reset values immediately. The first shift after release is sample 1 (fill_level=1).
- fill_level saturates at DEPTH and never wraps.
- Memory has no reset; unfilled taps are flagged by tap_valid=0.

## Test plan
- Default taps (WIDTH=8, DEPTH=256, NTAPS=4):
  - Stimulus: after reset, shift 0x01..0x20 continuously.
  - After the 20th shift: tap_data = {0x01 (tap3), 0x06, 0x0B, 0x10 (tap0)}.
  - tap_valid[3] first rises after shift 20; tap_valid[0] first rises after shift 5.
  - out_strobe pulses once per shift.
- Gapped input:
  - Stimulus: shift every 3rd cycle.
  - Taps are identical to the continuous case per sample index.
  - Outputs hold between shifts; out_strobe=0 on idle cycles.
- Reconfiguration:
  - Stimulus: write tap1 delay 1 in the same cycle as a shift of 0x40, then shift 0x41.
  - First edge: tap1 uses the old delay 10.
  - Second edge: tap1 = 0x41.
  - cfg_delay=0 acts as 1; cfg_delay=300 acts as 256.
- Wrap-around:
  - Stimulus: tap0 delay 256; shift 600 samples with value = index mod 256.
  - After shift n≥256: tap0 = (n−255) mod 256, tap_valid[0]=1.
  - fill_level stays at 256.
- Clear and reset:
  - Stimulus: clear with a simultaneous shift after 50 samples.
  - Result: fill_level=0, tap_valid=0, the sample is not stored, and taps refill from scratch.
  - Assert rst mid-burst: all outputs are 0 asynchronously and delays return to 5/10/15/20.

Source files
------------

// File: rtl/tap_delay_line.sv
// Multi-tap delay line over a circular sample buffer.
// Each tap has a run-time delay and a fill-based valid flag.
module tap_delay_line #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 256,
    parameter int NTAPS        = 4,
    parameter int DEFAULT_STEP = 5,
    localparam int AW = $clog2(DEPTH),
    localparam int DW = AW + 1,
    localparam int SW = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   shift,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   cfg_we,
    input  logic [SW-1:0]          cfg_sel,
    input  logic [DW-1:0]          cfg_delay,
    output logic [NTAPS*WIDTH-1:0] tap_data,
    output logic [NTAPS-1:0]       tap_valid,
    output logic                   out_strobe,
    output logic [DW-1:0]          fill_level
);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [DW-1:0]          dly [NTAPS];
    logic [AW-1:0]          rd_addr [NTAPS];
    logic [NTAPS*WIDTH-1:0] tap_nxt;
    logic [NTAPS-1:0]       vld_nxt;
    logic [DW:0]            fill_inc;
    logic                   do_shift;

    function automatic logic [DW-1:0] dflt(input int k);
        int v;
        v = (k + 1) * DEFAULT_STEP;
        if (v > DEPTH) v = DEPTH;
        if (v < 1) v = 1;
        return DW'(v);
    endfunction

    function automatic logic [DW-1:0] clamp(input logic [DW-1:0] d);
        if (d == '0) return DW'(1);
        if (d > DW'(DEPTH)) return DW'(DEPTH);
        return d;
    endfunction

    assign do_shift = shift && !clear;
    assign fill_inc = {1'b0, fill_level} + (DW+1)'(1);

    // wr_ptr - (d-1) == wr_ptr - d + 1; d=DEPTH aliases to 0 in AW bits
    always_comb begin
        tap_nxt = '0;
        vld_nxt = '0;
        for (int k = 0; k < NTAPS; k++) begin
            rd_addr[k] = wr_ptr - dly[k][AW-1:0] + AW'(1);
            if (dly[k] == DW'(1))
                tap_nxt[k*WIDTH +: WIDTH] = data_in;
            else
                tap_nxt[k*WIDTH +: WIDTH] = mem[rd_addr[k]];
            vld_nxt[k] = fill_inc >= {1'b0, dly[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (do_shift)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++)
                dly[k] <= dflt(k);
        end else if (cfg_we) begin
            for (int k = 0; k < NTAPS; k++)
                if (cfg_sel == SW'(k))
                    dly[k] <= clamp(cfg_delay);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            fill_level <= '0;
            tap_data   <= '0;
            tap_valid  <= '0;
            out_strobe <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            fill_level <= '0;
            tap_valid  <= '0;
            out_strobe <= 1'b0;
        end else if (shift) begin
            wr_ptr     <= wr_ptr + AW'(1);
            if (fill_level != DW'(DEPTH))
                fill_level <= fill_level + DW'(1);
            tap_data   <= tap_nxt;
            tap_valid  <= vld_nxt;
            out_strobe <= 1'b1;
        end else begin
            out_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tap_delay_line.sv
// Scoreboard bench for tap_delay_line: driver predicts with an
// ideal shift-register model, monitor pops on each out_strobe.
module tb_tap_delay_line;

    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int NTAPS = 4;
    localparam int DW    = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        shift;
    logic [7:0]  data_in;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [8:0]  cfg_delay;
    logic [31:0] tap_data;
    logic [3:0]  tap_valid;
    logic        out_strobe;
    logic [8:0]  fill_level;

    always #5 clk = ~clk;

    tap_delay_line #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NTAPS(NTAPS), .DEFAULT_STEP(5)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .shift(shift),
        .data_in(data_in), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_delay(cfg_delay), .tap_data(tap_data),
        .tap_valid(tap_valid), .out_strobe(out_strobe),
        .fill_level(fill_level)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] mask;
        logic [3:0]  valid;
        logic [8:0]  fill;
    } exp_t;

    exp_t q[$];
    exp_t last;
    exp_t mon_e;
    int   nvec = 0;
    int   nmis = 0;
    logic [7:0] sr [DEPTH];
    int   cnt;
    int   dm [NTAPS];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mreset();
        cnt = 0;
        for (int k = 0; k < NTAPS; k++)
            dm[k] = ((k + 1) * 5 > DEPTH) ? DEPTH : (k + 1) * 5;
        q.delete();
        last = '0;
        last.mask = '1;
    endtask

    task automatic step(input logic sh, input logic [7:0] d,
                        input logic clr, input logic we,
                        input logic [1:0] sel, input logic [8:0] cd);
        exp_t e;
        shift = sh; data_in = d; clear = clr;
        cfg_we = we; cfg_sel = sel; cfg_delay = cd;
        if (clr) begin
            cnt = 0;
        end else if (sh) begin
            for (int i = DEPTH - 1; i > 0; i--) sr[i] = sr[i-1];
            sr[0] = d;
            if (cnt < DEPTH) cnt++;
            e = '0;
            for (int k = 0; k < NTAPS; k++) begin
                e.data[k*8 +: 8] = sr[dm[k]-1];
                e.valid[k] = (cnt >= dm[k]);
                e.mask[k*8 +: 8] = e.valid[k] ? 8'hFF : 8'h00;
            end
            e.fill = 9'(cnt);
            q.push_back(e);
        end
        if (we)
            dm[sel] = (cd == 0) ? 1 : (cd > 256) ? 256 : int'(cd);
        @(posedge clk); #1;
        shift = 0; clear = 0; cfg_we = 0;
    endtask

    task automatic sh(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 2'd0, 9'd0);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 9'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        shift = 0; clear = 0; cfg_we = 0;
        data_in = 0; cfg_sel = 0; cfg_delay = 0;
        mreset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_strobe) begin
                if (q.size() == 0) begin
                    nvec++; nmis++;
                    $display("FAIL strobe: pulse with empty queue");
                end else begin
                    mon_e = q.pop_front();
                    chk("tap_data", 64'(tap_data & mon_e.mask),
                        64'(mon_e.data & mon_e.mask));
                    chk("tap_valid", 64'(tap_valid), 64'(mon_e.valid));
                    chk("fill_level", 64'(fill_level), 64'(mon_e.fill));
                    last = mon_e;
                end
            end else begin
                chk("hold", 64'(tap_data & last.mask),
                    64'(last.data & last.mask));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) sr[i] = 8'h00;
        do_reset();
        chk("reset_state", 64'({tap_data, tap_valid, out_strobe, fill_level}), 64'd0);

        // continuous
        for (int i = 1; i <= 32; i++) begin
            sh(8'(i));
            if (i == 4) chk("cont_v4", 64'(tap_valid), 64'h0);
            if (i == 5) chk("cont_v5", 64'(tap_valid), 64'h1);
            if (i == 19) chk("cont_v19", 64'(tap_valid), 64'h7);
            if (i == 20) begin
                chk("cont_d20", 64'(tap_data), 64'h01060B10);
                chk("cont_v20", 64'(tap_valid), 64'hF);
            end
        end

        // gapped
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            sh(8'(i));
            if (i == 20) chk("gap_d20", 64'(tap_data), 64'h01060B10);
            idle();
            idle();
            if (i == 20) begin
                chk("gap_hold", 64'(tap_data), 64'h01060B10);
                chk("gap_strobe", 64'(out_strobe), 64'd0);
            end
        end

        // reconfiguration
        do_reset();
        for (int i = 0; i < 16; i++) sh(8'(8'h30 + i));
        step(1'b1, 8'h40, 1'b0, 1'b1, 2'd1, 9'd1);
        chk("cfg_old", 64'(tap_data[15:8]), 64'h37);
        sh(8'h41);
        chk("cfg_new", 64'(tap_data[15:8]), 64'h41);
        step(1'b1, 8'h42, 1'b0, 1'b1, 2'd2, 9'd0);
        sh(8'h43);
        chk("cfg_zero", 64'(tap_data[23:16]), 64'h43);
        step(1'b1, 8'h44, 1'b0, 1'b1, 2'd3, 9'd300);
        sh(8'h45);
        chk("cfg_big_v", 64'(tap_valid), 64'h7);

        // wrap-around with d=DEPTH on tap0 and clamped tap3
        step(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 9'd0);
        chk("wrap_clr", 64'({tap_valid, fill_level}), 64'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 9'd256);
        for (int n = 1; n <= 600; n++) begin
            sh(8'(n % 256));
            if (n == 255) chk("wrap_v255", 64'(tap_valid[0]), 64'd0);
            if (n == 256) chk("wrap_256", 64'({tap_valid[0], tap_data[7:0]}), 64'h101);
            if (n == 600) begin
                chk("wrap_600", 64'(tap_data[7:0]), 64'h59);
                chk("wrap_fill", 64'(fill_level), 64'd256);
            end
        end

        // clear with simultaneous shift
        do_reset();
        for (int i = 0; i < 50; i++) sh(8'(8'h80 + i));
        step(1'b1, 8'hAA, 1'b1, 1'b0, 2'd0, 9'd0);
        chk("clr_state", 64'({tap_valid, out_strobe, fill_level}), 64'd0);
        sh(8'hB0);
        chk("clr_fill1", 64'({tap_valid, fill_level}), 64'h001);
        for (int i = 1; i < 5; i++) sh(8'(8'hB0 + i));
        chk("clr_tap0", 64'({tap_valid, tap_data[7:0]}), 64'h1B0);
        for (int i = 0; i < 20; i++) sh(8'(8'hC0 + i));

        // asynchronous reset mid-burst
        step(1'b1, 8'h11, 1'b0, 1'b1, 2'd2, 9'd3);
        for (int i = 0; i < 10; i++) sh(8'(8'h20 + i));
        #2 rst = 1'b1;
        #1 chk("arst_out", 64'({tap_data, tap_valid, out_strobe, fill_level}), 64'd0);
        mreset();
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            sh(8'(i));
            if (i == 1) chk("arst_fill1", 64'(fill_level), 64'd1);
        end
        chk("arst_dly", 64'({tap_data, fill_level}), {23'd0, 32'h01060B10, 9'd20});

        repeat (3) idle();
        chk("drain", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
